// File: rtl/sys_bridge_n.sv
// -----------------------------------------------------------------------------
// sys_bridge_n
//   Registered request/acknowledge bridge between the CPU data port and up to
//   NDEV memory-mapped devices. An access is decoded once and latched, the
//   selected device holds the transfer in WAIT for as long as it needs, and the
//   CPU sees a single-cycle cpu_ready pulse carrying read data and a bus error
//   flag. Device interrupt lines are synchronised into the CPU's HWInt field.
//
//   Optional feature macro: BRIDGE_TIMEOUT_EN
//     defined   : a saturating wait counter ends any WAIT that lasts TIMEOUT
//                 cycles without dev_ack, returning a bus error.
//     undefined : WAIT lasts until the selected device acks; errors are
//                 reported only for unmapped addresses.
//
//   Ports
//     clk        system clock, all state on rising edge
//     reset      asynchronous active-low reset
//     cpu_req    access request, held until cpu_ready
//     cpu_we     1 = write
//     cpu_addr   byte address
//     cpu_be     byte enables
//     cpu_wd     write data
//     cpu_ready  one-cycle completion pulse
//     cpu_rd     read data, valid with cpu_ready (0 otherwise)
//     cpu_err    bus error, valid with cpu_ready (0 otherwise)
//     dev_sel    one-hot device select, held through WAIT
//     dev_we     write strobe, latched cpu_we during WAIT
//     dev_addr   latched address
//     dev_be     latched byte enables
//     dev_wd     latched write data
//     dev_rd     packed device read data, slot i at [32i+31:32i]
//     dev_ack    device completion, only the selected bit is honoured
//     dev_irq    raw device interrupt lines
//     hwint      synchronised interrupts, bits >= NDEV read 0
// -----------------------------------------------------------------------------
module sys_bridge_n #(
  parameter int unsigned          NDEV    = 3,
  parameter logic [NDEV*32-1:0]   BASE    = {32'h0000_7f10, 32'h0000_7f00, 32'h0000_0000},
  parameter logic [NDEV*32-1:0]   MASK    = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_C000},
  parameter int unsigned          TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [31:0]          cpu_addr,
  input  logic [3:0]           cpu_be,
  input  logic [31:0]          cpu_wd,
  output logic                 cpu_ready,
  output logic [31:0]          cpu_rd,
  output logic                 cpu_err,
  output logic [NDEV-1:0]      dev_sel,
  output logic                 dev_we,
  output logic [31:0]          dev_addr,
  output logic [3:0]           dev_be,
  output logic [31:0]          dev_wd,
  input  logic [NDEV*32-1:0]   dev_rd,
  input  logic [NDEV-1:0]      dev_ack,
  input  logic [NDEV-1:0]      dev_irq,
  output logic [5:0]           hwint
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NDEV-1:0]   sel_q, sel_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wd_q, wd_d;
  logic [31:0]       rd_q, rd_d;
  logic              err_q, err_d;
  logic [NDEV-1:0]   irq_meta_q, irq_sync_q;

  logic [NDEV-1:0]   hit_sel;
  logic              ack_hit;
  logic [31:0]       rd_sel;
  logic              timeout_hit;

  // Address decode. Scanning from the highest slot down lets a lower slot
  // overwrite the result, so the lowest hitting index wins on overlap.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves it unassigned would infer a latch.
    hit_sel = '0;
    for (int i = int'(NDEV) - 1; i >= 0; i--) begin
      if ((cpu_addr & MASK[i*32 +: 32]) == BASE[i*32 +: 32]) begin
        hit_sel    = '0;
        hit_sel[i] = 1'b1;
      end
    end
  end

  // Only the ack and read data of the currently selected slot matter.
  always_comb begin
    ack_hit = |(dev_ack & sel_q);
    rd_sel  = '0;
    for (int i = 0; i < int'(NDEV); i++) begin
      if (sel_q[i]) rd_sel = dev_rd[i*32 +: 32];
    end
  end

`ifdef BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts completed WAIT cycles, so the edge that would make it reach
  // TIMEOUT is the last WAIT cycle: dev_sel is held for exactly TIMEOUT cycles.
  assign timeout_hit = (state_q == S_WAIT) && (cnt_q >= CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT && cnt_q != CNT_W'(TIMEOUT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and datapath latch logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          addr_d = cpu_addr;
          be_d   = cpu_be;
          wd_d   = cpu_wd;
          if (|hit_sel) begin
            sel_d   = hit_sel;
            we_d    = cpu_we;
            state_d = S_WAIT;
          end else begin
            // Unmapped: no device sees a strobe, the CPU gets an error.
            sel_d   = '0;
            we_d    = 1'b0;
            rd_d    = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_WAIT: begin
        // Ack is checked before timeout, so a same-cycle ack completes cleanly.
        if (ack_hit) begin
          rd_d    = we_q ? 32'h0 : rd_sel;
          err_d   = 1'b0;
          sel_d   = '0;
          we_d    = 1'b0;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          rd_d    = '0;
          err_d   = 1'b1;
          sel_d   = '0;
          we_d    = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset is asynchronous so dev_sel drops immediately even mid-WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wd_q       <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
      irq_meta_q <= '0;
      irq_sync_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values, independent of statement order.
      state_q    <= state_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wd_q       <= wd_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      irq_meta_q <= dev_irq;
      irq_sync_q <= irq_meta_q;
    end
  end

  assign cpu_ready = (state_q == S_DONE);
  assign cpu_rd    = cpu_ready ? rd_q  : 32'h0;
  assign cpu_err   = cpu_ready ? err_q : 1'b0;

  assign dev_sel   = sel_q;
  assign dev_we    = we_q;
  assign dev_addr  = addr_q;
  assign dev_be    = be_q;
  assign dev_wd    = wd_q;

  // Interrupts are level-sensitive; unused HWInt bits stay 0.
  always_comb begin
    hwint             = '0;
    hwint[NDEV-1:0]   = irq_sync_q;
  end

endmodule

// File: doc/sys_bridge_n.md
# sys_bridge_n

Parametrised system bridge between the CPU data port and up to NDEV memory-mapped devices (DM, Timer0, Timer1, future peripherals). It replaces the purely combinational decode with a registered request/acknowledge transaction, so devices may insert wait states. It also reports a bus error on unmapped or timed-out accesses and aggregates device interrupt lines into the CPU's HWInt field.

## Interface
- NDEV, 3, number of device slots (1..6)
- BASE, {32'h0000_7f10, 32'h0000_7f00, 32'h0000_0000}, packed NDEV×32 base addresses, slot i at bits [32i+31:32i]
- MASK, {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_C000}, packed NDEV×32 decode masks
- TIMEOUT, 16, max wait cycles for dev_ack before error (≥1)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  access request; held until cpu_ready
- cpu_we  in  1  1 = write
- cpu_addr  in  32  byte address
- cpu_be  in  4  byte enables
- cpu_wd  in  32  write data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rd  out  32  read data, valid with cpu_ready
- cpu_err  out  1  bus error, valid with cpu_ready
- dev_sel  out  NDEV  one-hot device select, held through WAIT
- dev_we  out  1  write strobe (= latched cpu_we during WAIT)
- dev_addr  out  32  latched address
- dev_be  out  4  latched byte enables
- dev_wd  out  32  latched write data
- dev_rd  in  NDEV×32  packed device read data
- dev_ack  in  NDEV  device completion; only the selected bit is honoured
- dev_irq  in  NDEV  raw device interrupt lines
- hwint  out  6  synchronised interrupts, bit i = dev_irq[i], bits ≥NDEV = 0

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE: when cpu_req = 1, latch addr/be/wd/we and decode with hit[i] = ((cpu_addr & MASK_i) == BASE_i). The lowest hitting index wins.
  - On a hit: set dev_sel to one-hot of the winner and go to WAIT.
  - On no hit: set err_r = 1, rd_r = 0, dev_sel = 0, and go to DONE.
- WAIT: dev_sel, dev_we, dev_addr, dev_be, dev_wd are stable.
  - If dev_ack[sel] = 1: rd_r ← dev_rd[sel] (0 for writes), err_r ← 0, clear dev_sel and dev_we, go to DONE.
  - Else increment wait counter.
- DONE: cpu_ready = 1, cpu_rd = rd_r, cpu_err = err_r for exactly one cycle, then go to IDLE.
  - A new request can be accepted the cycle after DONE.
- Acks from unselected devices and dev_ack outside WAIT are ignored.
- Wait counter: width $clog2(TIMEOUT+1). Cleared on entry to WAIT; saturates and does not wrap.
- cpu_rd and cpu_err read 0 whenever cpu_ready = 0.
- hwint is a two-flop synchroniser per line. It is level-sensitive and not latched; clearing is the device's job.

## Timing
- Reset (asynchronous assert, synchronous release): state = IDLE, all outputs 0, counter 0, synchroniser flops 0.
- Mapped access with ack in the first WAIT cycle:
  - req sampled at edge 0;
  - dev_sel high after edge 0;
  - ack sampled at edge 1;
  - cpu_ready high after edge 1.
  - Latency is 2 cycles from req sample to cpu_ready. Each extra wait cycle adds 1.
- Unmapped access: cpu_ready with cpu_err = 1 one cycle after the req sample.
- Timeout (BRIDGE_TIMEOUT_EN defined): if dev_ack is still absent after TIMEOUT WAIT cycles, the bridge clears dev_sel, sets err_r = 1 and rd_r = 0, and goes to DONE.
- Ack and timeout on the same cycle: ack wins, no error.
- cpu_req deasserted mid-transaction is ignored; the transaction completes.
- Reset during WAIT: dev_sel drops immediately (asynchronously); no cpu_ready is issued.
- hwint latency: 2 clk edges after the dev_irq change.

## Configuration
- BRIDGE_TIMEOUT_EN defined: wait counter and timeout error path are present as above.
- BRIDGE_TIMEOUT_EN undefined: no counter. WAIT persists until dev_ack, and cpu_err is raised only for unmapped addresses.

## Test plan
- Defaults, read 0x0000_0010 with DM (slot 0) acking in the first WAIT cycle with dev_rd[31:0] = 32'hDEAD_BEEF -> dev_sel = 3'b001 for 1 cycle; cpu_ready 2 cycles after req; cpu_rd = 32'hDEAD_BEEF; cpu_err = 0.
- Write 0x0000_7f04, data 32'h0000_0009, be = 4'hF, Timer0 (slot 1) acks after 3 wait cycles -> dev_sel = 3'b010 and dev_we = 1 held for 4 cycles; dev_wd = 9; cpu_ready 5 cycles after req.
- Read 0x0000_6000 (unmapped) -> cpu_ready and cpu_err = 1 one cycle after req; cpu_rd = 0; dev_sel never asserted.
- With BRIDGE_TIMEOUT_EN and TIMEOUT = 16, read 0x0000_7f10 with no ack -> dev_sel = 3'b100 for 16 cycles, then cpu_ready with cpu_err = 1 and cpu_rd = 0. A same-cycle ack at wait count 16 gives cpu_err = 0.
- Overlapping: assert reset (low) while in WAIT -> dev_sel = 0 at once; no cpu_ready. After release, a fresh read to slot 0 completes normally in 2 cycles.
- Pulse dev_irq[1] high for 4 cycles -> hwint = 6'b000010 starting 2 edges later for 4 cycles; hwint[5:3] always 0.
